// File: rtl/param_priority_arbiter_pkg.sv
// Shared arbiter definitions: mode encodings and the clog2 helper used to size
// index and counter fields across the arbiter family.
package param_priority_arbiter_pkg;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;

   // Ceiling log2 with a floor of 1 so a field is never zero bits wide.
   function automatic int arb_clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational wrap-around priority search: the first set request at or after
// start_i (wrapping N-1 -> 0) is returned as a one-hot pick plus its index.
module arb_prio_pick
   import param_priority_arbiter_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = arb_clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N-1:0]     pick_o,
   output logic [IDX_W-1:0] pick_idx_o,
   output logic             found_o
);

   always_comb begin
      int pos;
      pick_o     = '0;
      pick_idx_o = '0;
      found_o    = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start_i) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!found_o && req_i[pos]) begin
            found_o      = 1'b1;
            pick_o[pos]  = 1'b1;
            pick_idx_o   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/param_priority_arbiter.sv
// N-requester arbiter with a registered one-hot grant, fixed-priority or
// round-robin selection, and an optional bus-lock hold bounded in RR mode.
module param_priority_arbiter
   import param_priority_arbiter_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 4,
   localparam int IDX_W    = arb_clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_request,
   input  logic             in_mode,
   input  logic             in_hold,
   output logic [N-1:0]     out_grant,
   output logic             out_grant_valid,
   output logic [IDX_W-1:0] out_grant_idx
);

   localparam int CNT_W = arb_clog2(MAX_HOLD + 1);

   logic [N-1:0]     grant_q, grant_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

   logic             owner_req;
   logic [N-1:0]     others;
   logic             cap_hit;
   logic             keep;
   logic             rotate;
   logic [N-1:0]     pick_req;
   logic [IDX_W-1:0] pick_start;
   logic [N-1:0]     pick;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;

   assign owner_req = |(grant_q & in_request);
   assign others    = in_request & ~grant_q;
   assign cap_hit   = (hold_cnt_q == CNT_W'(MAX_HOLD));

   // RR tenure is only cut short when somebody else is actually waiting.
   assign keep   = in_hold && owner_req &&
                   ((in_mode == ARB_MODE_FIXED) || !cap_hit || (others == '0));
   assign rotate = in_hold && owner_req && (in_mode == ARB_MODE_RR) &&
                   cap_hit && (others != '0);

   // A forced rotation excludes the owner so a stale pointer cannot re-pick it.
   assign pick_req   = rotate ? others : in_request;
   assign pick_start = (in_mode == ARB_MODE_RR) ? rr_ptr_q : '0;

   arb_prio_pick #(.N(N)) u_pick (
      .req_i      (pick_req),
      .start_i    (pick_start),
      .pick_o     (pick),
      .pick_idx_o (pick_idx),
      .found_o    (pick_found)
   );

   always_comb begin
      grant_d  = grant_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      if (!keep) begin
         grant_d = pick;
         idx_d   = pick_idx;
         if ((in_mode == ARB_MODE_RR) && pick_found) begin
            rr_ptr_d = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + IDX_W'(1);
         end
      end
   end

   assign valid_d = |grant_d;

   always_comb begin
      hold_cnt_d = '0;
      if (grant_d == '0) begin
         hold_cnt_d = '0;
      end else if (grant_d == grant_q) begin
         hold_cnt_d = cap_hit ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
      end else begin
         hold_cnt_d = CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q    <= '0;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         grant_q    <= grant_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign out_grant       = grant_q;
   assign out_grant_valid = valid_q;
   assign out_grant_idx   = idx_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed, table-driven bench for param_priority_arbiter (N=4, MAX_HOLD=4).
module tb_param_priority_arbiter;

   localparam logic F  = 1'b0;
   localparam logic RR = 1'b1;

   logic       clk;
   logic       rst_n;
   logic [3:0] in_request;
   logic       in_mode;
   logic       in_hold;
   logic [3:0] out_grant;
   logic       out_grant_valid;
   logic [1:0] out_grant_idx;

   int checks;
   int errors;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       mode;
      logic       hold;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[$];

   param_priority_arbiter #(.N(4), .MAX_HOLD(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_request      (in_request),
      .in_mode         (in_mode),
      .in_hold         (in_hold),
      .out_grant       (out_grant),
      .out_grant_valid (out_grant_valid),
      .out_grant_idx   (out_grant_idx)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) r = 2'(i);
      end
      return r;
   endfunction

   function automatic void add(input logic rst, input logic [3:0] req,
                               input logic mode, input logic hold, input logic [3:0] exp);
      vec_t v;
      v.rst  = rst;
      v.req  = req;
      v.mode = mode;
      v.hold = hold;
      v.exp  = exp;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_outputs(input string name, input logic [3:0] exp);
      check({name, ".grant"}, out_grant, exp);
      check({name, ".valid"}, {3'b000, out_grant_valid}, {3'b000, |exp});
      check({name, ".idx"}, {2'b00, out_grant_idx}, {2'b00, idx_of(exp)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      in_request = 4'b0000;
      in_mode    = F;
      in_hold    = 1'b0;
      #1;
      check_outputs("reset", 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] prev;
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      in_request = 4'b0000;
      in_mode    = F;
      in_hold    = 1'b0;

      // 1: fixed priority, no hold
      add(1, 4'b0011, F, 0, 4'b0001);
      add(0, 4'b0111, F, 0, 4'b0001);
      add(0, 4'b1010, F, 0, 4'b0010);
      add(0, 4'b1100, F, 0, 4'b0100);
      // 2: round robin, no hold, wrap
      add(1, 4'b1111, RR, 0, 4'b0001);
      add(0, 4'b1111, RR, 0, 4'b0010);
      add(0, 4'b1111, RR, 0, 4'b0100);
      add(0, 4'b1111, RR, 0, 4'b1000);
      add(0, 4'b1111, RR, 0, 4'b0001);
      // 3: round robin, hold, bounded tenure
      for (int i = 0; i < 4; i++) add(i == 0, 4'b0011, RR, 1, 4'b0001);
      for (int i = 0; i < 4; i++) add(0, 4'b0011, RR, 1, 4'b0010);
      add(0, 4'b0011, RR, 1, 4'b0001);
      // 4: round robin, hold, no contender
      for (int i = 0; i < 8; i++) add(i == 0, 4'b0001, RR, 1, 4'b0001);
      // 5: fixed hold is unbounded, released when owner drops
      add(1, 4'b0100, F, 1, 4'b0100);
      add(0, 4'b0100, F, 1, 4'b0100);
      for (int i = 0; i < 4; i++) add(0, 4'b0101, F, 1, 4'b0100);
      add(0, 4'b0001, F, 1, 4'b0001);
      // rr_ptr retained across mode changes, then idle
      add(1, 4'b1111, RR, 0, 4'b0001);
      add(0, 4'b1111, F,  0, 4'b0001);
      add(0, 4'b1111, RR, 0, 4'b0010);
      add(0, 4'b0000, RR, 0, 4'b0000);
      // owner drop with simultaneous new requests
      add(1, 4'b0001, RR, 1, 4'b0001);
      add(0, 4'b0110, RR, 1, 4'b0010);
      add(0, 4'b0100, RR, 1, 4'b0100);

      prev = 4'b0000;
      foreach (vecs[n]) begin
         if (vecs[n].rst) begin
            do_reset();
            prev = 4'b0000;
         end
         @(negedge clk);
         in_request = vecs[n].req;
         in_mode    = vecs[n].mode;
         in_hold    = vecs[n].hold;
         #1;
         check($sformatf("lag[%0d]", n), out_grant, prev);
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec[%0d]", n), vecs[n].exp);
         prev = vecs[n].exp;
      end

      // 6: asynchronous reset between edges, pointer cleared
      do_reset();
      @(negedge clk);
      in_mode    = F;
      in_hold    = 1'b0;
      in_request = 4'b1000;
      @(posedge clk);
      #1;
      check_outputs("pre_async", 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("async_rst", 4'b0000);
      @(negedge clk);
      rst_n      = 1'b1;
      in_mode    = RR;
      in_request = 4'b1111;
      @(posedge clk);
      #1;
      check_outputs("post_rst_rr0", 4'b0001);
      @(posedge clk);
      #1;
      check_outputs("post_rst_rr1", 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
